// File: rtl/seg7_counter_mux.sv
// Multi-digit BCD/hex up/down counter with synchronous load, driving a
// time-multiplexed 7-segment display (shared segment bus + one-hot anodes).
module seg7_counter_mux #(
  parameter int DIGITS         = 4,
  parameter int RADIX          = 10,
  parameter int SCAN_DIV       = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0]        DIGIT_MAX = 4'(RADIX - 1);
  localparam logic [4:0]        RADIX_V   = 5'(RADIX);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  // Segment order a..g from MSB to LSB; hex letters blank out in BCD mode.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    if (RADIX == 10 && d > 4'd9) s = 7'b0000000;
    return s;
  endfunction

  // Counter next state: load clamps out-of-range digits, otherwise a
  // ripple carry/borrow walks up from digit 0.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = load_val[4*i +: 4];
        count_d[4*i +: 4] = ({1'b0, dig} < RADIX_V) ? dig : 4'd0;
      end
    end else if (en) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (carry) begin
          if (up) begin
            if (dig == DIGIT_MAX) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              count_d[4*i +: 4] = DIGIT_MAX;
            end else begin
              count_d[4*i +: 4] = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  // Scan timing and display: an/seg reflect the digit selected before the edge.
  always_comb begin
    logic [3:0] cur;
    cur    = 4'd0;
    an_d   = '0;
    idx_d  = idx_q;
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    if (scan_q == SCAN_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_d[i] = 1'b1;
        cur     = count_q[4*i +: 4];
      end
    end
    seg_d = decode(cur);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      an_q    <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign seg   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign an    = (SEG_ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_seg7_counter_mux.sv
// Directed bench for seg7_counter_mux: four instances (BCD, BCD active-low,
// hex with fast scan, single-digit BCD) share one set of inputs.
module tb_seg7_counter_mux;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;

  logic [15:0] count_bcd, count_inv, count_hex;
  logic [3:0]  count_one;
  logic        wrap_bcd, wrap_inv, wrap_hex, wrap_one;
  logic [6:0]  seg_bcd, seg_inv, seg_hex, seg_one;
  logic [3:0]  an_bcd, an_inv, an_hex;
  logic [0:0]  an_one;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  seg7_counter_mux #(.DIGITS(4), .RADIX(10), .SCAN_DIV(3), .SEG_ACTIVE_LOW(0)) u_bcd (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_bcd), .wrap(wrap_bcd), .seg(seg_bcd), .an(an_bcd));

  seg7_counter_mux #(.DIGITS(4), .RADIX(10), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1)) u_inv (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_inv), .wrap(wrap_inv), .seg(seg_inv), .an(an_inv));

  seg7_counter_mux #(.DIGITS(4), .RADIX(16), .SCAN_DIV(1), .SEG_ACTIVE_LOW(0)) u_hex (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count_hex), .wrap(wrap_hex), .seg(seg_hex), .an(an_hex));

  seg7_counter_mux #(.DIGITS(1), .RADIX(10), .SCAN_DIV(1), .SEG_ACTIVE_LOW(0)) u_one (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .count(count_one), .wrap(wrap_one), .seg(seg_one), .an(an_one));

  typedef struct {
    string       name;
    logic        ld;
    logic        en;
    logic        up;
    logic [15:0] val;
    logic [15:0] exp_bcd;
    logic        exp_wrap_bcd;
    logic [15:0] exp_hex;
    logic        exp_wrap_hex;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string name, logic ld, logic e, logic u, logic [15:0] val,
                              logic [15:0] eb, logic wb, logic [15:0] eh, logic wh);
    vec_t v;
    v.name = name; v.ld = ld; v.en = e; v.up = u; v.val = val;
    v.exp_bcd = eb; v.exp_wrap_bcd = wb; v.exp_hex = eh; v.exp_wrap_hex = wh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                       input logic [15:0] val);
    rst = r; load = ld; en = e; up = u; load_val = val;
  endtask

  initial begin
    logic [6:0] e_seg;
    logic [3:0] e_an;

    vecs[0]  = mk("load_0999",   1, 0, 0, 16'h0999, 16'h0999, 0, 16'h0999, 0);
    vecs[1]  = mk("bcd_carry",   0, 1, 1, 16'h0000, 16'h1000, 0, 16'h099A, 0);
    vecs[2]  = mk("load_9999",   1, 0, 0, 16'h9999, 16'h9999, 0, 16'h9999, 0);
    vecs[3]  = mk("wrap_up",     0, 1, 1, 16'h0000, 16'h0000, 1, 16'h999A, 0);
    vecs[4]  = mk("wrap_drop",   0, 0, 1, 16'h0000, 16'h0000, 0, 16'h999A, 0);
    vecs[5]  = mk("load_0000",   1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
    vecs[6]  = mk("wrap_down",   0, 1, 0, 16'h0000, 16'h9999, 1, 16'hFFFF, 1);
    vecs[7]  = mk("down_again",  0, 1, 0, 16'h0000, 16'h9998, 0, 16'hFFFE, 0);
    vecs[8]  = mk("load_over_en",1, 1, 1, 16'h12AB, 16'h1200, 0, 16'h12AB, 0);
    vecs[9]  = mk("inc_after",   0, 1, 1, 16'h0000, 16'h1201, 0, 16'h12AC, 0);
    vecs[10] = mk("load_clamp",  1, 0, 0, 16'hA9F0, 16'h0900, 0, 16'hA9F0, 0);
    vecs[11] = mk("borrow_2",    0, 1, 0, 16'h0000, 16'h0899, 0, 16'hA9EF, 0);
    vecs[12] = mk("hold",        0, 0, 0, 16'h4321, 16'h0899, 0, 16'hA9EF, 0);

    // Reset defaults: two cycles held, then release with en=0.
    drive(1, 0, 0, 1, 16'h0000);
    tick();
    tick();
    check("rst/count", count_bcd, 16'h0000);
    check("rst/wrap",  wrap_bcd,  1'b0);
    check("rst/seg",   seg_bcd,   7'b0000000);
    check("rst/an",    an_bcd,    4'b0000);
    check("rst/inv_seg", seg_inv, 7'b1111111);
    check("rst/inv_an",  an_inv,  4'b1111);
    drive(0, 0, 0, 1, 16'h0000);
    tick();
    check("first/an",    an_bcd,    4'b0001);
    check("first/seg",   seg_bcd,   7'b1111110);
    check("first/count", count_bcd, 16'h0000);

    // Table-driven counting vectors.
    for (int i = 0; i < 13; i++) begin
      drive(0, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].val);
      tick();
      check({vecs[i].name, "/bcd_count"}, count_bcd, vecs[i].exp_bcd);
      check({vecs[i].name, "/bcd_wrap"},  wrap_bcd,  vecs[i].exp_wrap_bcd);
      check({vecs[i].name, "/hex_count"}, count_hex, vecs[i].exp_hex);
      check({vecs[i].name, "/hex_wrap"},  wrap_hex,  vecs[i].exp_wrap_hex);
      check({vecs[i].name, "/inv_count"}, count_inv, vecs[i].exp_bcd);
    end

    // Single digit: wraps on back-to-back cycles each give their own pulse.
    drive(0, 1, 0, 1, 16'h0009);
    tick();
    check("one/load9", count_one, 4'h9);
    drive(0, 0, 1, 1, 16'h0000);
    tick();
    check("one/up_cnt",  count_one, 4'h0);
    check("one/up_wrap", wrap_one,  1'b1);
    drive(0, 0, 1, 0, 16'h0000);
    tick();
    check("one/dn_cnt",  count_one, 4'h9);
    check("one/dn_wrap", wrap_one,  1'b1);
    tick();
    check("one/dn2_cnt",  count_one, 4'h8);
    check("one/dn2_wrap", wrap_one,  1'b0);

    // Scan sequencing with count=4321 loaded on the first edge after reset.
    drive(1, 0, 0, 1, 16'h0000);
    tick();
    drive(0, 1, 0, 1, 16'h4321);
    for (int k = 1; k <= 13; k++) begin
      tick();
      load = 1'b0;
      e_an  = 4'b0001 << (((k - 1) / 3) % 4);
      e_seg = (k == 1) ? seg_tab[0] : seg_tab[((k - 1) / 3) % 4 + 1];
      check($sformatf("scan%0d/an", k),  an_bcd,  e_an);
      check($sformatf("scan%0d/seg", k), seg_bcd, e_seg);
      e_an  = ~e_an;
      e_seg = ~e_seg;
      check($sformatf("scan%0d/inv_an", k),  an_inv,  e_an);
      check($sformatf("scan%0d/inv_seg", k), seg_inv, e_seg);
      if (k <= 3) begin
        e_an  = 4'b0001 << (k - 1);
        e_seg = (k == 1) ? seg_tab[0] : seg_tab[k];
        check($sformatf("hscan%0d/an", k),  an_hex,  e_an);
        check($sformatf("hscan%0d/seg", k), seg_hex, e_seg);
      end
    end

    // Reset while counting with the scan on digit 2.
    drive(1, 0, 0, 1, 16'h0000);
    tick();
    drive(0, 0, 1, 1, 16'h0000);
    for (int k = 0; k < 6; k++) tick();
    check("mid/count_before", count_bcd, 16'h0006);
    check("mid/an_before",    an_bcd,    4'b0010);
    drive(1, 0, 1, 1, 16'h0000);
    tick();
    check("mid/count", count_bcd, 16'h0000);
    check("mid/wrap",  wrap_bcd,  1'b0);
    check("mid/an",    an_bcd,    4'b0000);
    check("mid/seg",   seg_bcd,   7'b0000000);
    check("mid/inv_an",  an_inv,  4'b1111);
    check("mid/inv_seg", seg_inv, 7'b1111111);
    drive(0, 0, 0, 1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      e_an = (k < 3) ? 4'b0001 : 4'b0010;
      check($sformatf("restart%0d/an", k),  an_bcd,  e_an);
      check($sformatf("restart%0d/seg", k), seg_bcd, 7'b1111110);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
